ip_chksum_arb: RTL and testbench
================================

Name: ip_chksum_arb

Overview:
Shares one IP checksum engine (cmd / req-stream / resp interfaces) between NUM_REQ requesters, e.g. RX ip_stream_format and TX header-build pipes.
- Round-robin arbitration per packet: a grant covers one cmd beat plus all req beats through last.
- Per-packet tags are queued in a small FIFO so checksum results are routed back to the requester that issued them, in order.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- DATA_WIDTH, 512, req data width in bits
- KEEP_WIDTH, DATA_WIDTH/8, req byte-keep width
- TAG_DEPTH, 4, outstanding-response tag FIFO depth (power of 2)
- REQ_W, $clog2(NUM_REQ), tag width

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset (0 = reset)
- req_cmd_val  input  NUM_REQ  per-requester cmd valid
- req_cmd_enable  input  NUM_REQ  per-requester cmd enable
- req_cmd_start  input  NUM_REQ*8  start offset, requester i at [8i+:8]
- req_cmd_offset  input  NUM_REQ*8  checksum insert offset
- req_cmd_init  input  NUM_REQ*16  initial checksum
- req_cmd_rdy  output  NUM_REQ  cmd ready
- req_data  input  NUM_REQ*DATA_WIDTH  req data
- req_keep  input  NUM_REQ*KEEP_WIDTH  req keep
- req_val  input  NUM_REQ  req valid
- req_last  input  NUM_REQ  req last
- req_rdy  output  NUM_REQ  req ready
- req_resp_val  output  NUM_REQ  result valid
- req_resp_chksum  output  16  result value, shared by all requesters
- req_resp_rdy  input  NUM_REQ  result ready
- chksum_cmd_val/enable  output  1 each  to engine
- chksum_cmd_start/offset  output  8 each  to engine
- chksum_cmd_init  output  16  to engine
- chksum_cmd_rdy  input  1  from engine
- chksum_req_data  output  DATA_WIDTH  to engine
- chksum_req_keep  output  KEEP_WIDTH  to engine
- chksum_req_val, chksum_req_last  output  1 each  to engine
- chksum_req_rdy  input  1  from engine
- chksum_resp_val  input  1  from engine
- chksum_resp_chksum  input  16  from engine
- chksum_resp_rdy  output  1  to engine

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, tag FIFO empty. All outputs 0 (val/rdy low, data/keep/cmd fields 0).
- State machine:
  - IDLE: if any req_cmd_val and tag FIFO not full, select the first set bit searching from rr_ptr upward with wrap. Register grant_id. Go to CMD. Decision is 1 cycle; the cmd is presented the next cycle.
  - CMD:
    - chksum_cmd_* = fields[grant_id]; chksum_cmd_val=req_cmd_val[grant_id]; req_cmd_rdy[grant_id]=chksum_cmd_rdy; all other req_cmd_rdy=0.
    - On handshake: push grant_id to tag FIFO; rr_ptr = grant_id+1 mod NUM_REQ; go to DATA.
  - DATA:
    - chksum_req_* = req_*[grant_id]; req_rdy[grant_id]=chksum_req_rdy; others 0.
    - On handshake with last=1: go to IDLE. Next grant is decided in the following cycle, so there is 1 bubble between packets.
- Requester-side cmd fields must be held stable while val=1 (AXI-style). The arbiter does not re-arbitrate once granted; a requester dropping val in CMD stalls the arbiter.
- req beats from non-granted requesters: rdy=0, always.
- Response path (independent of grant state):
  - Head tag t routes the result: req_resp_val[t]=chksum_resp_val & ~empty; chksum_resp_rdy=req_resp_rdy[t] & ~empty; req_resp_chksum=chksum_resp_chksum.
  - Pop on handshake.
  - Resp while FIFO empty: chksum_resp_rdy=0 (protocol error, not dropped).
- Tag FIFO:
  - Full blocks new grants in IDLE only; an in-progress packet finishes.
  - Push and pop in the same cycle are both allowed, including when full (count unchanged).
  - Pointers wrap mod TAG_DEPTH.
- rst low mid-packet: immediate return to reset state; outstanding tags discarded. The engine is reset by the same rst.

Optional Feature:
- Macro: IP_CHKSUM_ARB_STATS_EN.
- Defined:
  - Adds output stats_grant_cnt (NUM_REQ*32): per-requester grant counters, +1 on cmd handshake, wrap at 2^32, cleared on reset.
  - Adds output stats_fifo_full_cycles (32): counts cycles in IDLE with a pending cmd blocked by a full FIFO.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Single requester 0: cmd {start=0, offset=52, init=0}, 2 beats (second last) -> engine sees identical cmd and beats; resp 0xB1E6 returned only on req_resp_val[0].
- Both requesters assert cmd in the same cycle after reset -> req 0 granted first, then req 1. With continuous load, grants alternate 0,1,0,1; 1 idle cycle between packets.
- req 1 asserts req_val while req 0 is granted -> req_rdy[1]=0 until req 0 last handshake; no interleaving on chksum_req_*.
- TAG_DEPTH=4: 4 packets sent, engine withholds resp -> 5th cmd not granted. One resp popped -> 5th granted the following cycle. Responses delivered in tag order 0,1,0,1.
- Stall: chksum_req_rdy low for 3 cycles mid-packet and req_resp_rdy[t] low for 2 cycles -> no beat lost or duplicated; resp held stable until accepted.
- rst=0 asserted during DATA of req 1 -> next cycle all val/rdy outputs 0, FIFO empty, rr_ptr=0. With STATS_EN defined, counters are 0.

Source files
------------

// File: rtl/ip_chksum_arb.sv
// ----------------------------------------------------------------------------
// ip_chksum_arb
//
// Shares one IP checksum engine between NUM_REQ requesters. Each grant covers
// one packet: a single cmd beat followed by req beats up to and including the
// beat flagged last. Requesters are served round-robin. The requester id of
// every accepted cmd is pushed into a small tag FIFO so that engine results,
// which come back in packet order, are steered to the requester that issued
// them.
//
// Ports
//   clk, rst            clock, synchronous active-low reset (0 = reset)
//   req_cmd_*           per-requester cmd channel (val/enable/start/offset/init,
//                       rdy back); requester i occupies slice i of each bus
//   req_data/keep/val/last, req_rdy
//                       per-requester req data stream
//   req_resp_val/rdy    per-requester result handshake
//   req_resp_chksum     result value, shared by all requesters
//   chksum_cmd_*        cmd channel towards the engine
//   chksum_req_*        req data stream towards the engine
//   chksum_resp_*       result channel from the engine
//
// Optional feature (macro IP_CHKSUM_ARB_STATS_EN)
//   stats_grant_cnt        per-requester cmd-handshake counters (32 bit each)
//   stats_fifo_full_cycles cycles spent idle with a cmd blocked by a full FIFO
// ----------------------------------------------------------------------------
module ip_chksum_arb #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int TAG_DEPTH  = 4,
    parameter int REQ_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_REQ-1:0]            req_cmd_val,
    input  logic [NUM_REQ-1:0]            req_cmd_enable,
    input  logic [NUM_REQ*8-1:0]          req_cmd_start,
    input  logic [NUM_REQ*8-1:0]          req_cmd_offset,
    input  logic [NUM_REQ*16-1:0]         req_cmd_init,
    output logic [NUM_REQ-1:0]            req_cmd_rdy,

    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*KEEP_WIDTH-1:0] req_keep,
    input  logic [NUM_REQ-1:0]            req_val,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_rdy,

    output logic [NUM_REQ-1:0]            req_resp_val,
    output logic [15:0]                   req_resp_chksum,
    input  logic [NUM_REQ-1:0]            req_resp_rdy,

    output logic                          chksum_cmd_val,
    output logic                          chksum_cmd_enable,
    output logic [7:0]                    chksum_cmd_start,
    output logic [7:0]                    chksum_cmd_offset,
    output logic [15:0]                   chksum_cmd_init,
    input  logic                          chksum_cmd_rdy,

    output logic [DATA_WIDTH-1:0]         chksum_req_data,
    output logic [KEEP_WIDTH-1:0]         chksum_req_keep,
    output logic                          chksum_req_val,
    output logic                          chksum_req_last,
    input  logic                          chksum_req_rdy,

    input  logic                          chksum_resp_val,
    input  logic [15:0]                   chksum_resp_chksum,
    output logic                          chksum_resp_rdy
`ifdef IP_CHKSUM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stats_grant_cnt,
    output logic [31:0]                   stats_fifo_full_cycles
`endif
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    logic [REQ_W-1:0]   grant_id;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   rr_pick;
    logic [REQ_W-1:0]   rr_next;

    logic [REQ_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   tag_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [REQ_W-1:0]   head_tag;

    logic               cmd_fire;
    logic               data_fire;
    logic               tag_push;
    logic               tag_pop;

    logic [7:0]            start_arr  [NUM_REQ];
    logic [7:0]            offset_arr [NUM_REQ];
    logic [15:0]           init_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr   [NUM_REQ];
    logic [KEEP_WIDTH-1:0] keep_arr   [NUM_REQ];

    // Split the flat per-requester buses into arrays so the grant mux is a
    // plain array index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign start_arr[g]  = req_cmd_start[g*8 +: 8];
        assign offset_arr[g] = req_cmd_offset[g*8 +: 8];
        assign init_arr[g]   = req_cmd_init[g*16 +: 16];
        assign data_arr[g]   = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign keep_arr[g]   = req_keep[g*KEEP_WIDTH +: KEEP_WIDTH];
    end

    assign fifo_full  = (tag_count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (tag_count == '0);
    assign head_tag   = tag_mem[rd_ptr];

    assign cmd_fire  = (state == CMD)  && req_cmd_val[grant_id] && chksum_cmd_rdy;
    assign data_fire = (state == DATA) && req_val[grant_id] && chksum_req_rdy;
    assign tag_push  = cmd_fire;
    assign tag_pop   = chksum_resp_val && chksum_resp_rdy;

    assign rr_next = (grant_id == REQ_W'(NUM_REQ - 1)) ? '0 : grant_id + REQ_W'(1);

    // Round-robin pick: first pending cmd at or above rr_ptr, wrapping.
    // The sum rr_ptr+i carries one extra bit so the wrap works for any
    // NUM_REQ, not only powers of two.
    always_comb begin
        logic [REQ_W:0] idx_w;
        logic           found;
        rr_pick = rr_ptr;
        found   = 1'b0;
        idx_w   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_w = {1'b0, rr_ptr} + (REQ_W+1)'(i);
            if (idx_w >= (REQ_W+1)'(NUM_REQ)) begin
                idx_w = idx_w - (REQ_W+1)'(NUM_REQ);
            end
            if (!found && req_cmd_val[idx_w[REQ_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx_w[REQ_W-1:0];
            end
        end
    end

    // Packet-level arbiter. A new grant is only taken in IDLE with tag room;
    // once granted, the arbiter stays with that requester through its last
    // req beat, which leaves one idle cycle between packets.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if ((|req_cmd_val) && !fifo_full) begin
                        grant_id <= rr_pick;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_fire) begin
                        rr_ptr <= rr_next;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (data_fire && req_last[grant_id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Forward path mux. Readies must pass straight through in the same
    // cycle, so these are decoded from the registered state and grant rather
    // than registered themselves; everything is zero outside CMD/DATA.
    always_comb begin
        chksum_cmd_val    = 1'b0;
        chksum_cmd_enable = 1'b0;
        chksum_cmd_start  = '0;
        chksum_cmd_offset = '0;
        chksum_cmd_init   = '0;
        req_cmd_rdy       = '0;
        chksum_req_data   = '0;
        chksum_req_keep   = '0;
        chksum_req_val    = 1'b0;
        chksum_req_last   = 1'b0;
        req_rdy           = '0;
        case (state)
            CMD: begin
                chksum_cmd_val        = req_cmd_val[grant_id];
                chksum_cmd_enable     = req_cmd_enable[grant_id];
                chksum_cmd_start      = start_arr[grant_id];
                chksum_cmd_offset     = offset_arr[grant_id];
                chksum_cmd_init       = init_arr[grant_id];
                req_cmd_rdy[grant_id] = chksum_cmd_rdy;
            end
            DATA: begin
                chksum_req_data   = data_arr[grant_id];
                chksum_req_keep   = keep_arr[grant_id];
                chksum_req_val    = req_val[grant_id];
                chksum_req_last   = req_last[grant_id];
                req_rdy[grant_id] = chksum_req_rdy;
            end
            default: ;
        endcase
    end

    // Result steering by the oldest outstanding tag. With no tag queued the
    // engine is simply not acknowledged, so a stray result stays pending.
    always_comb begin
        req_resp_val           = '0;
        req_resp_val[head_tag] = chksum_resp_val & ~fifo_empty;
        chksum_resp_rdy        = req_resp_rdy[head_tag] & ~fifo_empty;
    end

    assign req_resp_chksum = chksum_resp_chksum;

    // Tag FIFO. Push and pop may coincide; the count only moves when exactly
    // one of them happens. Pointers wrap naturally as TAG_DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_count <= '0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            if (tag_push) begin
                tag_mem[wr_ptr] <= grant_id;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (tag_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + CNT_W'(1);
                2'b01:   tag_count <= tag_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef IP_CHKSUM_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] full_cycles;

    // Activity counters; both wrap at 2^32 and clear with the arbiter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            full_cycles <= '0;
        end else begin
            if (cmd_fire) begin
                grant_cnt[grant_id] <= grant_cnt[grant_id] + 32'd1;
            end
            if ((state == IDLE) && (|req_cmd_val) && fifo_full) begin
                full_cycles <= full_cycles + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign stats_grant_cnt[g*32 +: 32] = grant_cnt[g];
    end
    assign stats_fifo_full_cycles = full_cycles;
`endif

endmodule

// File: tb/tb_ip_chksum_arb.sv
// ----------------------------------------------------------------------------
// tb_ip_chksum_arb
//
// Directed bench for ip_chksum_arb with randomised payloads. The bench plays
// both the requesters and the checksum engine. A small reference model keeps
// the round-robin origin, the queue of outstanding result owners and the
// per-requester grant totals, and every observed output is compared with it.
// Build with +define+IP_CHKSUM_ARB_STATS_EN to also cover the counters.
// ----------------------------------------------------------------------------
module tb_ip_chksum_arb;

    localparam int NUM_REQ   = 2;
    localparam int DW        = 512;
    localparam int KW        = DW / 8;
    localparam int TAG_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;

    logic [NUM_REQ-1:0]      req_cmd_val;
    logic [NUM_REQ-1:0]      req_cmd_enable;
    logic [NUM_REQ*8-1:0]    req_cmd_start;
    logic [NUM_REQ*8-1:0]    req_cmd_offset;
    logic [NUM_REQ*16-1:0]   req_cmd_init;
    logic [NUM_REQ-1:0]      req_cmd_rdy;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ*KW-1:0]   req_keep;
    logic [NUM_REQ-1:0]      req_val;
    logic [NUM_REQ-1:0]      req_last;
    logic [NUM_REQ-1:0]      req_rdy;
    logic [NUM_REQ-1:0]      req_resp_val;
    logic [15:0]             req_resp_chksum;
    logic [NUM_REQ-1:0]      req_resp_rdy;
    logic                    chksum_cmd_val;
    logic                    chksum_cmd_enable;
    logic [7:0]              chksum_cmd_start;
    logic [7:0]              chksum_cmd_offset;
    logic [15:0]             chksum_cmd_init;
    logic                    chksum_cmd_rdy;
    logic [DW-1:0]           chksum_req_data;
    logic [KW-1:0]           chksum_req_keep;
    logic                    chksum_req_val;
    logic                    chksum_req_last;
    logic                    chksum_req_rdy;
    logic                    chksum_resp_val;
    logic [15:0]             chksum_resp_chksum;
    logic                    chksum_resp_rdy;
`ifdef IP_CHKSUM_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]   stats_grant_cnt;
    logic [31:0]             stats_fifo_full_cycles;
`endif

    int nChecks = 0;
    int nFail   = 0;

    // Reference model state
    int          rrModel = 0;
    int          tagQ[$];
    int          grantCnt[NUM_REQ];
    int          fullCyclesModel = 0;
    logic [7:0]  cmdStart[NUM_REQ];
    logic [7:0]  cmdOffset[NUM_REQ];
    logic [15:0] cmdInit[NUM_REQ];
    logic        cmdEnable[NUM_REQ];

    ip_chksum_arb #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DW),
        .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_cmd_val(req_cmd_val),
        .req_cmd_enable(req_cmd_enable),
        .req_cmd_start(req_cmd_start),
        .req_cmd_offset(req_cmd_offset),
        .req_cmd_init(req_cmd_init),
        .req_cmd_rdy(req_cmd_rdy),
        .req_data(req_data),
        .req_keep(req_keep),
        .req_val(req_val),
        .req_last(req_last),
        .req_rdy(req_rdy),
        .req_resp_val(req_resp_val),
        .req_resp_chksum(req_resp_chksum),
        .req_resp_rdy(req_resp_rdy),
        .chksum_cmd_val(chksum_cmd_val),
        .chksum_cmd_enable(chksum_cmd_enable),
        .chksum_cmd_start(chksum_cmd_start),
        .chksum_cmd_offset(chksum_cmd_offset),
        .chksum_cmd_init(chksum_cmd_init),
        .chksum_cmd_rdy(chksum_cmd_rdy),
        .chksum_req_data(chksum_req_data),
        .chksum_req_keep(chksum_req_keep),
        .chksum_req_val(chksum_req_val),
        .chksum_req_last(chksum_req_last),
        .chksum_req_rdy(chksum_req_rdy),
        .chksum_resp_val(chksum_resp_val),
        .chksum_resp_chksum(chksum_resp_chksum),
        .chksum_resp_rdy(chksum_resp_rdy)
`ifdef IP_CHKSUM_ARB_STATS_EN
        ,
        .stats_grant_cnt(stats_grant_cnt),
        .stats_fifo_full_cycles(stats_fifo_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence itself wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic applyStimulus(input int r, input logic [7:0] s, input logic [7:0] o,
                                 input logic [15:0] ini, input logic en);
        cmdStart[r]  = s;
        cmdOffset[r] = o;
        cmdInit[r]   = ini;
        cmdEnable[r] = en;
        req_cmd_start[r*8 +: 8]   = s;
        req_cmd_offset[r*8 +: 8]  = o;
        req_cmd_init[r*16 +: 16]  = ini;
        req_cmd_enable[r]         = en;
        req_cmd_val[r]            = 1'b1;
    endtask

    task automatic raiseRandomCmd(input int r);
        applyStimulus(r, 8'($urandom), 8'($urandom), 16'($urandom), 1'b1);
    endtask

    task automatic clearInputs();
        req_cmd_val        = '0;
        req_cmd_enable     = '0;
        req_cmd_start      = '0;
        req_cmd_offset     = '0;
        req_cmd_init       = '0;
        req_data           = '0;
        req_keep           = '0;
        req_val            = '0;
        req_last           = '0;
        req_resp_rdy       = '0;
        chksum_cmd_rdy     = 1'b1;
        chksum_req_rdy     = 1'b1;
        chksum_resp_val    = 1'b0;
        chksum_resp_chksum = '0;
    endtask

    // Reset with busy stimulus on every input; one clock later all handshake
    // outputs must be quiet and the tag FIFO empty.
    task automatic resetDut();
        rst             = 1'b0;
        req_cmd_val     = '1;
        req_val         = '1;
        req_last        = '0;
        chksum_resp_val = 1'b1;
        req_resp_rdy    = '1;
        tick();
        checkOutput("rst_chksum_cmd_val", chksum_cmd_val, 0);
        checkOutput("rst_chksum_cmd_start", chksum_cmd_start, 0);
        checkOutput("rst_chksum_req_val", chksum_req_val, 0);
        checkOutput("rst_chksum_req_data", chksum_req_data, 0);
        checkOutput("rst_req_cmd_rdy", req_cmd_rdy, 0);
        checkOutput("rst_req_rdy", req_rdy, 0);
        checkOutput("rst_req_resp_val", req_resp_val, 0);
        checkOutput("rst_chksum_resp_rdy", chksum_resp_rdy, 0);
`ifdef IP_CHKSUM_ARB_STATS_EN
        checkOutput("rst_stats_grant", stats_grant_cnt, 0);
        checkOutput("rst_stats_full", stats_fifo_full_cycles, 0);
`endif
        clearInputs();
        tick();
        rst = 1'b1;
        tagQ.delete();
        rrModel = 0;
        fullCyclesModel = 0;
        for (int i = 0; i < NUM_REQ; i++) grantCnt[i] = 0;
    endtask

    // Waits (bounded) for the engine cmd, checks that the model's round-robin
    // choice is the one presented, and completes the cmd handshake.
    task automatic waitGrant(output int g, output int waited);
        int expId;
        expId  = -1;
        g      = -1;
        waited = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = (rrModel + i) % NUM_REQ;
            if (expId < 0 && req_cmd_val[c]) expId = c;
        end
        #1;
        while (waited < 20 && chksum_cmd_val !== 1'b1) begin
            tick();
            waited++;
        end
        checkOutput("cmd_presented", chksum_cmd_val, 1);
        if (chksum_cmd_val === 1'b1 && expId >= 0) begin
            checkOutput("cmd_rdy_route", req_cmd_rdy, 1 << expId);
            checkOutput("cmd_start", chksum_cmd_start, cmdStart[expId]);
            checkOutput("cmd_offset", chksum_cmd_offset, cmdOffset[expId]);
            checkOutput("cmd_init", chksum_cmd_init, cmdInit[expId]);
            checkOutput("cmd_enable", chksum_cmd_enable, cmdEnable[expId]);
            g = expId;
            tick();
            req_cmd_val[expId] = 1'b0;
            tagQ.push_back(expId);
            rrModel = (expId + 1) % NUM_REQ;
            grantCnt[expId]++;
            #1;
            checkOutput("cmd_after_hs", chksum_cmd_val, 0);
        end
    endtask

    // Streams n beats from requester r; the engine withholds ready for
    // stallLen cycles from stallStart. Optionally the other requester pushes
    // its own beats at the same time, which must never be accepted.
    task automatic sendBeats(input int r, input int n, input int stallStart,
                             input int stallLen, input bit otherActive);
        logic [DW-1:0] beats[$];
        logic [KW-1:0] keeps[$];
        int b, cyc, o;
        b = 0;
        cyc = 0;
        o = (r + 1) % NUM_REQ;
        for (int i = 0; i < n; i++) begin
            beats.push_back(randData());
            keeps.push_back((i == n - 1) ? KW'({$urandom, $urandom}) : {KW{1'b1}});
        end
        while (b < n && cyc < 50) begin
            chksum_req_rdy = !(cyc >= stallStart && cyc < stallStart + stallLen);
            req_val[r] = 1'b1;
            req_data[r*DW +: DW] = beats[b];
            req_keep[r*KW +: KW] = keeps[b];
            req_last[r] = (b == n - 1);
            if (otherActive) begin
                req_val[o] = 1'b1;
                req_data[o*DW +: DW] = ~beats[b];
                req_keep[o*KW +: KW] = ~keeps[b];
                req_last[o] = 1'b1;
            end
            #1;
            checkOutput("req_val_fwd", chksum_req_val, 1);
            checkOutput("req_data_fwd", chksum_req_data, beats[b]);
            checkOutput("req_keep_fwd", chksum_req_keep, keeps[b]);
            checkOutput("req_last_fwd", chksum_req_last, b == n - 1);
            checkOutput("req_rdy_route", req_rdy, chksum_req_rdy ? (1 << r) : 0);
            tick();
            if (chksum_req_rdy) b++;
            cyc++;
        end
        checkOutput("beats_delivered", b, n);
        req_val        = '0;
        req_last       = '0;
        chksum_req_rdy = 1'b1;
    endtask

    // Engine returns a result; the owner holds ready low for holdOff cycles.
    task automatic deliverResp(input logic [15:0] v, input int holdOff);
        int t;
        t = tagQ[0];
        chksum_resp_val    = 1'b1;
        chksum_resp_chksum = v;
        req_resp_rdy       = '0;
        for (int i = 0; i < holdOff; i++) begin
            #1;
            checkOutput("resp_val_held", req_resp_val, 1 << t);
            checkOutput("resp_rdy_held", chksum_resp_rdy, 0);
            checkOutput("resp_chksum_held", req_resp_chksum, v);
            tick();
        end
        req_resp_rdy = NUM_REQ'(1 << t);
        #1;
        checkOutput("resp_val_route", req_resp_val, 1 << t);
        checkOutput("resp_rdy_pass", chksum_resp_rdy, 1);
        checkOutput("resp_chksum", req_resp_chksum, v);
        tick();
        void'(tagQ.pop_front());
        chksum_resp_val = 1'b0;
        req_resp_rdy    = '0;
    endtask

    initial begin
        int g, waited;
        clearInputs();
        $display("[TB] start");

        // ---------------- reset state ----------------
        resetDut();

        // ---------------- single requester 0 ----------------
        applyStimulus(0, 8'd0, 8'd52, 16'h0000, 1'b1);
        waitGrant(g, waited);
        checkOutput("single_grant_id", g, 0);
        checkOutput("single_decision_latency", waited, 1);
        sendBeats(0, 2, -1, 0, 1'b0);
        deliverResp(16'hB1E6, 0);
        chksum_resp_val    = 1'b1;
        chksum_resp_chksum = 16'h1234;
        req_resp_rdy       = '1;
        #1;
        checkOutput("resp_empty_val", req_resp_val, 0);
        checkOutput("resp_empty_rdy", chksum_resp_rdy, 0);
        tick();
        chksum_resp_val = 1'b0;
        req_resp_rdy    = '0;

        // ---------------- both requesters, continuous load ----------------
        resetDut();
        raiseRandomCmd(0);
        raiseRandomCmd(1);
        for (int k = 0; k < 4; k++) begin
            waitGrant(g, waited);
            checkOutput("alt_order", g, k % 2);
            checkOutput("alt_bubble", waited, 1);
            if (g >= 0) sendBeats(g, 1 + int'($urandom_range(2)), -1, 0, k == 0);
            if (k < 2 && g >= 0) raiseRandomCmd(g);
        end

        // Tag FIFO now full: a pending cmd must not be granted
        raiseRandomCmd(0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("full_blocks_grant", chksum_cmd_val, 0);
            tick();
            fullCyclesModel++;
        end
        deliverResp(16'($urandom), 2);
        fullCyclesModel += 3;
        #1;
        checkOutput("grant_after_pop_idle", chksum_cmd_val, 0);
        waitGrant(g, waited);
        checkOutput("grant_after_pop_id", g, 0);
        checkOutput("grant_after_pop_latency", waited, 1);
        if (g >= 0) sendBeats(g, 3, 1, 3, 1'b0);
        while (tagQ.size() > 0) deliverResp(16'($urandom), 0);
`ifdef IP_CHKSUM_ARB_STATS_EN
        for (int i = 0; i < NUM_REQ; i++)
            checkOutput("stats_grant_cnt", stats_grant_cnt[i*32 +: 32], grantCnt[i]);
        checkOutput("stats_full_cycles", stats_fifo_full_cycles, fullCyclesModel);
`endif

        // ---------------- reset during DATA of requester 1 ----------------
        raiseRandomCmd(1);
        waitGrant(g, waited);
        checkOutput("pre_reset_grant", g, 1);
        req_val[1]           = 1'b1;
        req_data[DW +: DW]   = randData();
        req_keep[KW +: KW]   = '1;
        req_last[1]          = 1'b0;
        #1;
        checkOutput("pre_reset_rdy", req_rdy, 2'b10);
        tick();
        resetDut();
        raiseRandomCmd(0);
        raiseRandomCmd(1);
        waitGrant(g, waited);
        checkOutput("rr_ptr_after_reset", g, 0);
        if (g >= 0) sendBeats(g, 1, -1, 0, 1'b0);
        deliverResp(16'($urandom), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
